// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmit path between two
// word-wide requesters. The granted word is sent LSB byte first, one byte per
// tx_start / tx_done_tick handshake.
// Optional feature macro: TX_FRAME_HEADER_EN prefixes every frame with a
// header byte {grant_id, per-requester frame counter}.
module uart_tx_arbiter #(
  parameter int NB_DATA = 8,
  parameter int NB_WORD = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [NB_WORD-1:0] req0_word,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [NB_WORD-1:0] req1_word,
  output logic               req1_ready,
  input  logic               tx_done_tick,
  output logic               tx_start,
  output logic [NB_DATA-1:0] din,
  output logic               busy,
  output logic               grant_id
);

  localparam int N_BYTES = NB_WORD / NB_DATA;
  localparam int CW      = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N_BYTES - 1);

`ifdef TX_FRAME_HEADER_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_HDR  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;
`endif

  state_t             state_r, state_nxt_s;
  logic [NB_WORD-1:0] shift_r, shift_nxt_s;
  logic [CW-1:0]      cnt_r, cnt_nxt_s;
  logic               ptr_r, ptr_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               grant_r, grant_nxt_s;
  logic               start_r, start_nxt_s;
  logic [NB_DATA-1:0] din_r, din_nxt_s;
  logic [1:0]         ready_r, ready_nxt_s;
  logic               gsel_s;
`ifdef TX_FRAME_HEADER_EN
  logic [NB_DATA-2:0] fcnt0_r, fcnt0_nxt_s;
  logic [NB_DATA-2:0] fcnt1_r, fcnt1_nxt_s;
  logic               hdr_r, hdr_nxt_s;
`endif

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_nxt_s = state_r;
    shift_nxt_s = shift_r;
    cnt_nxt_s   = cnt_r;
    ptr_nxt_s   = ptr_r;
    busy_nxt_s  = busy_r;
    grant_nxt_s = grant_r;
    start_nxt_s = 1'b0;
    din_nxt_s   = din_r;
    ready_nxt_s = 2'b00;
`ifdef TX_FRAME_HEADER_EN
    fcnt0_nxt_s = fcnt0_r;
    fcnt1_nxt_s = fcnt1_r;
    hdr_nxt_s   = hdr_r;
`endif
    // Pointer only matters on a tie; otherwise the lone valid requester wins.
    if (req0_valid && req1_valid) begin
      gsel_s = ptr_r;
    end else begin
      gsel_s = req1_valid;
    end

    case (state_r)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          shift_nxt_s = gsel_s ? req1_word : req0_word;
          cnt_nxt_s   = '0;
          grant_nxt_s = gsel_s;
          busy_nxt_s  = 1'b1;
          ready_nxt_s = gsel_s ? 2'b10 : 2'b01;
`ifdef TX_FRAME_HEADER_EN
          state_nxt_s = ST_HDR;
`else
          state_nxt_s = ST_SEND;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
`ifdef TX_FRAME_HEADER_EN
      ST_HDR: begin
        start_nxt_s = 1'b1;
        din_nxt_s   = {grant_r, (grant_r ? fcnt1_r : fcnt0_r)};
        hdr_nxt_s   = 1'b1;
        state_nxt_s = ST_WAIT;
      end
`endif
      ST_SEND: begin
        start_nxt_s = 1'b1;
        din_nxt_s   = shift_r[NB_DATA-1:0];
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done_tick) begin
`ifdef TX_FRAME_HEADER_EN
          // Header done: data bytes start without consuming the shift register.
          if (hdr_r) begin
            hdr_nxt_s   = 1'b0;
            state_nxt_s = ST_SEND;
          end else
`endif
          if (cnt_r != LAST_CNT) begin
            shift_nxt_s = shift_r >> NB_DATA;
            cnt_nxt_s   = cnt_r + CW'(1);
            state_nxt_s = ST_SEND;
          end else begin
            busy_nxt_s  = 1'b0;
            ptr_nxt_s   = ~grant_r;
            state_nxt_s = ST_IDLE;
`ifdef TX_FRAME_HEADER_EN
            if (grant_r) begin
              fcnt1_nxt_s = fcnt1_r + {{(NB_DATA-2){1'b0}}, 1'b1};
            end else begin
              fcnt0_nxt_s = fcnt0_r + {{(NB_DATA-2){1'b0}}, 1'b1};
            end
`endif
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; async reset abandons any frame in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      shift_r <= '0;
      cnt_r   <= '0;
      ptr_r   <= 1'b0;
      busy_r  <= 1'b0;
      grant_r <= 1'b0;
      start_r <= 1'b0;
      din_r   <= '0;
      ready_r <= 2'b00;
`ifdef TX_FRAME_HEADER_EN
      fcnt0_r <= '0;
      fcnt1_r <= '0;
      hdr_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      shift_r <= shift_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ptr_r   <= ptr_nxt_s;
      busy_r  <= busy_nxt_s;
      grant_r <= grant_nxt_s;
      start_r <= start_nxt_s;
      din_r   <= din_nxt_s;
      ready_r <= ready_nxt_s;
`ifdef TX_FRAME_HEADER_EN
      fcnt0_r <= fcnt0_nxt_s;
      fcnt1_r <= fcnt1_nxt_s;
      hdr_r   <= hdr_nxt_s;
`endif
    end
  end

  assign req0_ready = ready_r[0];
  assign req1_ready = ready_r[1];
  assign tx_start   = start_r;
  assign din        = din_r;
  assign busy       = busy_r;
  assign grant_id   = grant_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a transaction-level model (byte queue per frame,
// round-robin pointer) is compared against the DUT on every cycle, and the
// logged byte/grant sequences are pinned against hand-computed literals.
module tb_uart_tx_arbiter;
  localparam int NB_DATA  = 8;
  localparam int NB_WORD  = 32;
  localparam int RESP_DLY = 20;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               req0_valid = 1'b0, req1_valid = 1'b0;
  logic [NB_WORD-1:0] req0_word = '0, req1_word = '0;
  logic               req0_ready, req1_ready;
  logic               tx_done_tick;
  logic               tx_start;
  logic [NB_DATA-1:0] din;
  logic               busy, grant_id;
  logic               resp_tick = 1'b0, spur_tick = 1'b0;
  int                 resp_cnt = 0;

  int checks = 0;
  int errors = 0;

  logic [7:0] all_log[$];
  logic [7:0] data_log[$];
  logic       grant_log[$];
  int         fidx = 0;

  // model state
  logic [7:0] m_q[$];
  int         m_due = 0;
  bit         m_active = 1'b0, m_waiting = 1'b0, m_ptr = 1'b0, m_gid = 1'b0, m_busy = 1'b0;
  bit         exp_start = 1'b0;
  logic [7:0] exp_din = 8'h00;
  logic [1:0] exp_ready = 2'b00;
`ifdef TX_FRAME_HEADER_EN
  logic [6:0] m_fcnt[2];
`endif

  assign tx_done_tick = resp_tick | spur_tick;

  uart_tx_arbiter #(.NB_DATA(NB_DATA), .NB_WORD(NB_WORD)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_word(req0_word), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_word(req1_word), .req1_ready(req1_ready),
    .tx_done_tick(tx_done_tick), .tx_start(tx_start), .din(din),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of the model: grant, byte scheduling, completion.
  task automatic model_step();
    bit g;
    logic [NB_WORD-1:0] w;
    exp_start = 1'b0;
    exp_ready = 2'b00;
    if (!reset) begin
      m_q.delete();
      m_active = 1'b0; m_waiting = 1'b0; m_due = 0;
      m_ptr = 1'b0; m_gid = 1'b0; m_busy = 1'b0; exp_din = 8'h00;
`ifdef TX_FRAME_HEADER_EN
      m_fcnt[0] = 7'd0; m_fcnt[1] = 7'd0;
`endif
    end else if (!m_active) begin
      if (req0_valid || req1_valid) begin
        g = (req0_valid && req1_valid) ? m_ptr : req1_valid;
        w = g ? req1_word : req0_word;
        m_q.delete();
        for (int i = 0; i < NB_WORD / NB_DATA; i++) m_q.push_back(w[8*i +: 8]);
`ifdef TX_FRAME_HEADER_EN
        m_q.push_front({g, m_fcnt[g]});
`endif
        m_active = 1'b1; m_gid = g; m_busy = 1'b1; m_due = 1;
        exp_ready[g] = 1'b1;
      end
    end else if (m_due > 0) begin
      m_due--;
      if (m_due == 0) begin
        exp_start = 1'b1;
        exp_din   = m_q[0];
        m_waiting = 1'b1;
      end
    end else if (m_waiting && tx_done_tick) begin
      m_waiting = 1'b0;
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_active = 1'b0; m_busy = 1'b0; m_ptr = !m_gid;
`ifdef TX_FRAME_HEADER_EN
        m_fcnt[m_gid] = m_fcnt[m_gid] + 7'd1;
`endif
      end else begin
        m_due = 1;
      end
    end
  endtask

  // Model step on each edge, then compare DUT outputs 1 time unit later.
  always @(posedge clock) begin
    model_step();
    #1;
    chk("outs{start,busy,gid,rdy1,rdy0}", {59'd0, tx_start, busy, grant_id, req1_ready, req0_ready},
        {59'd0, exp_start, m_busy, m_gid, exp_ready[1], exp_ready[0]});
    if (exp_start) chk("din", {56'd0, din}, {56'd0, exp_din});
    if (req0_ready || req1_ready) begin
      grant_log.push_back(req1_ready);
      fidx = 0;
    end
    if (tx_start) begin
      all_log.push_back(din);
`ifdef TX_FRAME_HEADER_EN
      if (fidx > 0) data_log.push_back(din);
`else
      data_log.push_back(din);
`endif
      fidx++;
    end
  end

  // Transmitter stand-in: tx_done_tick RESP_DLY cycles after each tx_start.
  always @(negedge clock) begin
    if (!reset) begin
      resp_cnt  <= 0;
      resp_tick <= 1'b0;
    end else begin
      resp_tick <= (resp_cnt == 1);
      if (tx_start) resp_cnt <= RESP_DLY;
      else if (resp_cnt > 0) resp_cnt <= resp_cnt - 1;
    end
  end

  task automatic clear_logs();
    all_log.delete(); data_log.delete(); grant_log.delete();
  endtask

  task automatic check_bytes(input string name, input bit use_all, input logic [79:0] exp, input int n);
    logic [7:0] q[$];
    q = use_all ? all_log : data_log;
    chk({name, "_count"}, 64'(q.size()), 64'(n));
    if (q.size() == n)
      for (int i = 0; i < n; i++) chk(name, {56'd0, q[i]}, {56'd0, exp[8*(n-1-i) +: 8]});
  endtask

  task automatic check_grants(input string name, input logic [3:0] exp, input int n);
    chk({name, "_count"}, 64'(grant_log.size()), 64'(n));
    if (grant_log.size() == n)
      for (int i = 0; i < n; i++) chk(name, {63'd0, grant_log[i]}, {63'd0, exp[n-1-i]});
  endtask

  // Serve max0/max1 frames; drop each valid after its last ready pulse.
  task automatic drive(input int max0, input int max1, input bit spur, input int budget,
                       output int c0, output int c1);
    int n;
    bit done;
    c0 = 0; c1 = 0; n = 0; done = 1'b0;
    req0_valid = (max0 > 0);
    req1_valid = (max1 > 0);
    while (!done) begin
      @(negedge clock);
      n++;
      spur_tick = 1'b0;
      if (req0_ready) begin c0++; if (spur) spur_tick = 1'b1; end
      if (req1_ready) begin c1++; if (spur) spur_tick = 1'b1; end
      if (c0 >= max0) req0_valid = 1'b0;
      if (c1 >= max1) req1_valid = 1'b0;
      if (!req0_valid && !req1_valid && !busy) done = 1'b1;
      if (n >= budget) begin
        chk("drive_timeout", 64'(n), 64'(budget + 1));
        req0_valid = 1'b0; req1_valid = 1'b0; done = 1'b1;
      end
    end
  endtask

  initial begin
    int c0, c1, n;
    repeat (3) @(negedge clock);
    chk("reset_outputs", {57'd0, tx_start, din, busy, grant_id, req1_ready, req0_ready}, 64'd0);
    reset = 1'b1;
    @(negedge clock);

    // single request
    clear_logs();
    req0_word = 32'hDEADBEEF;
    drive(1, 0, 1'b0, 600, c0, c1);
    check_bytes("t1_bytes", 1'b0, 80'hEFBEADDE, 4);
    chk("t1_ready0_pulses", 64'(c0), 64'd1);
    check_grants("t1_grants", 4'b0000, 1);

    // simultaneous from reset
    reset = 1'b0;
    req0_word = 32'h11223344; req1_word = 32'hAABBCCDD;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clock); clear_logs();
    @(negedge clock); reset = 1'b1;
    drive(1, 1, 1'b0, 1000, c0, c1);
    check_bytes("t2_bytes", 1'b0, 80'h44332211DDCCBBAA, 8);
    check_grants("t2_grants", 4'b0001, 2);

    // fairness
    clear_logs();
    drive(2, 2, 1'b0, 2000, c0, c1);
    check_grants("t3_grants", 4'b0101, 4);
    chk("t3_ready0_pulses", 64'(c0), 64'd2);
    chk("t3_ready1_pulses", 64'(c1), 64'd2);

    // spurious ticks in IDLE and in the SEND cycle
    clear_logs();
    spur_tick = 1'b1; @(negedge clock); spur_tick = 1'b0; @(negedge clock);
    req0_word = 32'h01020304;
    drive(1, 0, 1'b1, 600, c0, c1);
    check_bytes("t4_bytes", 1'b0, 80'h04030201, 4);

    // reset in the middle of a frame; pointer was 1 before it
    clear_logs();
    req0_word = 32'hCAFEF00D; req0_valid = 1'b1; n = 0;
    while (data_log.size() < 3 && n < 300) begin
      @(negedge clock); n++;
      if (req0_ready) req0_valid = 1'b0;
    end
    chk("t5_reached_3rd_byte", 64'(data_log.size()), 64'd3);
    chk("t5_first_byte", {56'd0, data_log[0]}, 64'h0D);
    chk("t5_second_byte", {56'd0, data_log[1]}, 64'hF0);
    #2 reset = 1'b0;
    #1 chk("t5_async_reset_outputs", {57'd0, tx_start, din, busy, grant_id, req1_ready, req0_ready}, 64'd0);
    @(negedge clock);
    req0_word = 32'h99AABBCC; req1_word = 32'h55667788;
    req0_valid = 1'b1; req1_valid = 1'b1;
    clear_logs();
    @(negedge clock); reset = 1'b1;
    drive(1, 1, 1'b0, 1000, c0, c1);
    check_bytes("t5_bytes", 1'b0, 80'hCCBBAA9988776655, 8);
    check_grants("t5_grants", 4'b0001, 2);

    // two back-to-back req1 frames (header bytes when enabled)
    reset = 1'b0;
    @(negedge clock); clear_logs();
    @(negedge clock); reset = 1'b1;
    req1_word = 32'h0A0B0C0D;
    drive(0, 2, 1'b0, 1200, c0, c1);
    check_grants("t6_grants", 4'b0011, 2);
    check_bytes("t6_data", 1'b0, 80'h0D0C0B0A0D0C0B0A, 8);
`ifdef TX_FRAME_HEADER_EN
    check_bytes("t6_all", 1'b1, 80'h800D0C0B0A810D0C0B0A, 10);
`else
    check_bytes("t6_all", 1'b1, 80'h0D0C0B0A0D0C0B0A, 8);
`endif

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
